seg7_scan_encoder: RTL and testbench

//  Receive-side counterpart of the BCD-to-7-segment decoder. Observes a multiplexed,

---
 rtl/seg7_scan_encoder.sv | 131 +++++++++++++
 tb/tb_seg7_scan_encoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_encoder.sv
// Watches a multiplexed active-low 7-segment bus and turns each settled digit back into BCD.
// Every settled digit is captured. When all digits have been seen, they are presented together as one frame.
module seg7_scan_encoder #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic                  digit_valid,
  output logic [2:0]            digit_idx,
  output logic [3:0]            digit_bcd,
  output logic                  frame_valid,
  output logic [4*DIGITS-1:0]   frame_bcd,
  output logic                  frame_err
);

  localparam int SW = 7 + DIGITS;
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC);
  localparam logic [7:0] CNT_M1  = 8'(STABLE_CYC - 1);

  logic [SW-1:0]         samp_in, samp;
  logic [7:0]            cnt;
  logic [3:0]            n_low;
  logic                  an_ok;
  logic [2:0]            an_idx;
  logic [3:0]            enc_bcd;
  logic                  enc_err;
  logic                  capture;
  logic                  frame_done;
  logic [DIGITS-1:0]     mask, mask_nxt;
  logic [4*DIGITS-1:0]   slots, slots_nxt;
  logic                  err_acc, err_nxt;

  assign samp_in = {seg_n, an_n};

  always_comb begin
    n_low  = 4'd0;
    an_idx = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_n[i]) begin
        n_low  = n_low + 4'd1;
        an_idx = 3'(i);
      end
    end
    an_ok = (n_low == 4'd1);
  end

  always_comb begin
    enc_err = 1'b0;
    case (seg_n)
      7'b0000001: enc_bcd = 4'd0;
      7'b1001111: enc_bcd = 4'd1;
      7'b0010010: enc_bcd = 4'd2;
      7'b0000110: enc_bcd = 4'd3;
      7'b1001100: enc_bcd = 4'd4;
      7'b0100100: enc_bcd = 4'd5;
      7'b0100000: enc_bcd = 4'd6;
      7'b0001111: enc_bcd = 4'd7;
      7'b0000000: enc_bcd = 4'd8;
      7'b0001100: enc_bcd = 4'd9;
      7'b1111111: enc_bcd = 4'hF;
      default: begin
        enc_bcd = 4'hE;
        enc_err = 1'b1;
      end
    endcase
  end

  // The input matches the held sample here, so encoding the live input equals encoding the sample.
  assign capture = an_ok && (samp_in == samp) && (cnt == CNT_M1);

  always_comb begin
    mask_nxt  = mask;
    slots_nxt = slots;
    err_nxt   = err_acc | enc_err;
    for (int i = 0; i < DIGITS; i++) begin
      if (an_idx == 3'(i)) begin
        mask_nxt[i]        = 1'b1;
        slots_nxt[4*i +: 4] = enc_bcd;
      end
    end
    frame_done = &mask_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp        <= {7'b0000000, {DIGITS{1'b1}}};
      cnt         <= 8'd0;
      mask        <= '0;
      slots       <= '0;
      err_acc     <= 1'b0;
      digit_valid <= 1'b0;
      digit_idx   <= 3'd0;
      digit_bcd   <= 4'd0;
      frame_valid <= 1'b0;
      frame_bcd   <= '0;
      frame_err   <= 1'b0;
    end else begin
      samp        <= samp_in;
      digit_valid <= capture;
      frame_valid <= 1'b0;
      if (!an_ok)
        cnt <= 8'd0;
      else if (samp_in == samp) begin
        if (cnt != CNT_MAX)
          cnt <= cnt + 8'd1;
      end else
        cnt <= 8'd1;
      if (capture) begin
        digit_idx <= an_idx;
        digit_bcd <= enc_bcd;
        // The completing digit goes into this frame. The mask is cleared so that nothing carries over to the next frame.
        if (frame_done) begin
          frame_bcd   <= slots_nxt;
          frame_err   <= err_nxt;
          frame_valid <= 1'b1;
          mask        <= '0;
          err_acc     <= 1'b0;
          slots       <= slots_nxt;
        end else begin
          mask    <= mask_nxt;
          err_acc <= err_nxt;
          slots   <= slots_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_encoder.sv
// Directed bench for seg7_scan_encoder with DIGITS=4, STABLE_CYC=4.
// A negedge monitor counts the output pulses and latches the values that came with them.
module tb_seg7_scan_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  seg_n = 7'b1111111;
  logic [3:0]  an_n = 4'b1111;
  logic        digit_valid;
  logic [2:0]  digit_idx;
  logic [3:0]  digit_bcd;
  logic        frame_valid;
  logic [15:0] frame_bcd;
  logic        frame_err;

  int total = 0;
  int bad = 0;
  int dv_cnt = 0;
  int fv_cnt = 0;
  logic [3:0]  last_dbcd = 4'd0;
  logic [2:0]  last_didx = 3'd0;
  logic [15:0] last_fbcd = 16'd0;
  logic        last_ferr = 1'b0;

  seg7_scan_encoder #(.DIGITS(4), .STABLE_CYC(4)) dut (
    .clk(clk), .reset(reset), .seg_n(seg_n), .an_n(an_n),
    .digit_valid(digit_valid), .digit_idx(digit_idx), .digit_bcd(digit_bcd),
    .frame_valid(frame_valid), .frame_bcd(frame_bcd), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (digit_valid) begin
      dv_cnt    = dv_cnt + 1;
      last_dbcd = digit_bcd;
      last_didx = digit_idx;
    end
    if (frame_valid) begin
      fv_cnt    = fv_cnt + 1;
      last_fbcd = frame_bcd;
      last_ferr = frame_err;
    end
  end

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: pat = 7'b0000001;
      1: pat = 7'b1001111;
      2: pat = 7'b0010010;
      3: pat = 7'b0000110;
      4: pat = 7'b1001100;
      5: pat = 7'b0100100;
      6: pat = 7'b0100000;
      7: pat = 7'b0001111;
      8: pat = 7'b0000000;
      default: pat = 7'b0001100;
    endcase
  endfunction

  function automatic logic [3:0] sel(input int idx);
    logic [3:0] a;
    a = 4'b1111;
    a[idx] = 1'b0;
    return a;
  endfunction

  task automatic hold(input logic [6:0] s, input logic [3:0] a, input int n);
    seg_n = s;
    an_n  = a;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    hold(7'b1111111, 4'b1111, n);
  endtask

  task automatic scan4(input int d0, input int d1, input int d2, input int d3, input int n);
    hold(pat(d0), sel(0), n);
    hold(pat(d1), sel(1), n);
    hold(pat(d2), sel(2), n);
    hold(pat(d3), sel(3), n);
    idle(2);
  endtask

  task automatic test_reset;
    #3;
    total++; if (digit_valid !== 1'b0) begin bad++; $display("FAIL reset_dv got=%b exp=0", digit_valid); end
    total++; if (digit_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", digit_idx); end
    total++; if (digit_bcd !== 4'd0) begin bad++; $display("FAIL reset_dbcd got=%h exp=0", digit_bcd); end
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b exp=0", frame_valid); end
    total++; if (frame_bcd !== 16'd0) begin bad++; $display("FAIL reset_fbcd got=%h exp=0", frame_bcd); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_full_frame;
    int dv0, fv0;
    dv0 = dv_cnt; fv0 = fv_cnt;
    scan4(1, 2, 3, 4, 6);
    total++; if (dv_cnt - dv0 !== 4) begin bad++; $display("FAIL full_dv got=%0d exp=4", dv_cnt - dv0); end
    total++; if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL full_fv got=%0d exp=1", fv_cnt - fv0); end
    total++; if (last_fbcd !== 16'h4321) begin bad++; $display("FAIL full_fbcd got=%h exp=4321", last_fbcd); end
    total++; if (last_ferr !== 1'b0) begin bad++; $display("FAIL full_ferr got=%b exp=0", last_ferr); end
    total++; if (last_didx !== 3'd3) begin bad++; $display("FAIL full_idx got=%0d exp=3", last_didx); end
    total++; if (frame_bcd !== 16'h4321) begin bad++; $display("FAIL full_hold got=%h exp=4321", frame_bcd); end
  endtask

  task automatic test_reset_midframe;
    int fv0;
    hold(pat(5), sel(0), 6);
    hold(pat(6), sel(1), 6);
    hold(pat(9), sel(2), 2);
    #2 reset = 1'b1;
    #1;
    total++; if (frame_bcd !== 16'd0) begin bad++; $display("FAIL midrst_fbcd got=%h exp=0", frame_bcd); end
    total++; if (digit_bcd !== 4'd0) begin bad++; $display("FAIL midrst_dbcd got=%h exp=0", digit_bcd); end
    @(posedge clk); #1;
    reset = 1'b0;
    fv0 = fv_cnt;
    idle(2);
    hold(pat(7), sel(2), 6);
    hold(pat(8), sel(3), 6);
    idle(2);
    total++; if (fv_cnt - fv0 !== 0) begin bad++; $display("FAIL midrst_partial got=%0d exp=0", fv_cnt - fv0); end
    hold(pat(1), sel(0), 6);
    hold(pat(2), sel(1), 6);
    idle(2);
    total++; if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL midrst_fv got=%0d exp=1", fv_cnt - fv0); end
    total++; if (last_fbcd !== 16'h8721) begin bad++; $display("FAIL midrst_fbcd2 got=%h exp=8721", last_fbcd); end
  endtask

  task automatic test_glitch;
    int dv0;
    dv0 = dv_cnt;
    hold(pat(5), sel(0), 3);
    hold(pat(6), sel(0), 3);
    idle(3);
    total++; if (dv_cnt - dv0 !== 0) begin bad++; $display("FAIL glitch_short got=%0d exp=0", dv_cnt - dv0); end
    hold(pat(7), sel(0), 4);
    idle(2);
    total++; if (dv_cnt - dv0 !== 1) begin bad++; $display("FAIL glitch_exact got=%0d exp=1", dv_cnt - dv0); end
    total++; if (last_dbcd !== 4'd7) begin bad++; $display("FAIL glitch_bcd got=%h exp=7", last_dbcd); end
    hold(pat(8), sel(1), 6);
    hold(pat(9), sel(2), 6);
    hold(pat(0), sel(3), 6);
    idle(2);
    total++; if (last_fbcd !== 16'h0987) begin bad++; $display("FAIL glitch_frame got=%h exp=0987", last_fbcd); end
  endtask

  task automatic test_bad_anode;
    int dv0, fv0;
    dv0 = dv_cnt; fv0 = fv_cnt;
    hold(pat(3), 4'b1111, 10);
    hold(pat(3), 4'b1100, 10);
    idle(2);
    total++; if (dv_cnt - dv0 !== 0) begin bad++; $display("FAIL badan_dv got=%0d exp=0", dv_cnt - dv0); end
    scan4(9, 8, 7, 6, 6);
    total++; if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL badan_fv got=%0d exp=1", fv_cnt - fv0); end
    total++; if (last_fbcd !== 16'h6789) begin bad++; $display("FAIL badan_fbcd got=%h exp=6789", last_fbcd); end
  endtask

  task automatic test_encoding;
    hold(7'b1111111, sel(0), 6);
    idle(1);
    total++; if (last_dbcd !== 4'hF) begin bad++; $display("FAIL enc_blank got=%h exp=f", last_dbcd); end
    hold(pat(1), sel(1), 6);
    hold(pat(2), sel(2), 6);
    hold(pat(3), sel(3), 6);
    idle(2);
    total++; if (last_fbcd !== 16'h321F) begin bad++; $display("FAIL enc_blank_frame got=%h exp=321f", last_fbcd); end
    total++; if (last_ferr !== 1'b0) begin bad++; $display("FAIL enc_blank_err got=%b exp=0", last_ferr); end
    hold(pat(5), sel(0), 6);
    hold(7'b1010101, sel(1), 6);
    idle(1);
    total++; if (last_dbcd !== 4'hE) begin bad++; $display("FAIL enc_bad got=%h exp=e", last_dbcd); end
    hold(pat(2), sel(2), 6);
    hold(pat(3), sel(3), 6);
    idle(2);
    total++; if (last_fbcd !== 16'h32E5) begin bad++; $display("FAIL enc_bad_frame got=%h exp=32e5", last_fbcd); end
    total++; if (last_ferr !== 1'b1) begin bad++; $display("FAIL enc_bad_err got=%b exp=1", last_ferr); end
    scan4(1, 1, 1, 1, 6);
    total++; if (last_ferr !== 1'b0) begin bad++; $display("FAIL enc_err_clear got=%b exp=0", last_ferr); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL enc_err_held got=%b exp=0", frame_err); end
  endtask

  task automatic test_recapture;
    int dv0, fv0;
    dv0 = dv_cnt; fv0 = fv_cnt;
    hold(pat(5), sel(0), 6);
    idle(2);
    hold(pat(7), sel(0), 6);
    hold(pat(1), sel(1), 6);
    hold(pat(2), sel(2), 6);
    idle(2);
    total++; if (fv_cnt - fv0 !== 0) begin bad++; $display("FAIL recap_early got=%0d exp=0", fv_cnt - fv0); end
    hold(pat(3), sel(3), 6);
    idle(2);
    total++; if (dv_cnt - dv0 !== 5) begin bad++; $display("FAIL recap_dv got=%0d exp=5", dv_cnt - dv0); end
    total++; if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL recap_fv got=%0d exp=1", fv_cnt - fv0); end
    total++; if (last_fbcd !== 16'h3217) begin bad++; $display("FAIL recap_fbcd got=%h exp=3217", last_fbcd); end
  endtask

  task automatic test_back_to_back;
    int fv0;
    fv0 = fv_cnt;
    hold(pat(4), sel(0), 4);
    hold(pat(3), sel(1), 4);
    hold(pat(2), sel(2), 4);
    hold(pat(1), sel(3), 4);
    hold(pat(8), sel(0), 4);
    hold(pat(6), sel(1), 4);
    hold(pat(0), sel(2), 4);
    hold(pat(9), sel(3), 4);
    idle(2);
    total++; if (fv_cnt - fv0 !== 2) begin bad++; $display("FAIL b2b_fv got=%0d exp=2", fv_cnt - fv0); end
    total++; if (last_fbcd !== 16'h9068) begin bad++; $display("FAIL b2b_fbcd got=%h exp=9068", last_fbcd); end
    hold(pat(1), sel(0), 6);
    hold(pat(1), sel(1), 6);
    hold(pat(1), sel(2), 6);
    idle(2);
    total++; if (fv_cnt - fv0 !== 2) begin bad++; $display("FAIL b2b_noleak got=%0d exp=2", fv_cnt - fv0); end
  endtask

  initial begin
    test_reset;
    test_full_frame;
    test_reset_midframe;
    test_glitch;
    test_bad_anode;
    test_encoding;
    test_recapture;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
